// File: rtl/demux_1_to_4_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_to_4_buffered
//  Purpose  : Registered 1-to-4 demultiplexer with valid/ready handshakes.
//             One input word is steered to one of four single-entry output
//             registers selected by in_sel; every output path starts at a flop.
//             Optional broadcast mode (macro DEMUX_BCAST_EN) adds in_bcast,
//             which writes the word into all four slots at once.
//  Revision : 1.0  initial release
// ============================================================================
module demux_1_to_4_buffered #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX_BCAST_EN
    ,
    input  logic             in_bcast
`endif
);

    localparam int c_SLOTS = 4;

    logic [WIDTH-1:0] r_data [c_SLOTS];
    logic [3:0]       r_valid;

    logic [3:0]       w_can_take;
    logic [3:0]       w_target;
    logic [3:0]       w_write;
    logic             w_ready;
    logic             w_accept;

    // A slot can take a word when it is empty or is being drained this cycle.
    assign w_can_take = ~r_valid | out_ready;

    // Target mask and readiness: broadcast needs every slot free, otherwise
    // only the selected slot matters, so a stalled slot never blocks others.
    always_comb begin
        w_target = 4'b0001 << in_sel;
        w_ready  = w_can_take[in_sel];
`ifdef DEMUX_BCAST_EN
        if (in_bcast) begin
            w_target = 4'b1111;
            w_ready  = &w_can_take;
        end
`endif
    end

    assign in_ready = w_ready & ~reset;
    assign w_accept = in_valid & in_ready;
    assign w_write  = w_accept ? w_target : 4'b0000;

    generate
        for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
            // Per-slot register: a write wins over a drain, so a same-cycle
            // drain and write keeps the slot full with the new word.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else if (w_write[k]) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_1     = r_data[0];
    assign out_2     = r_data[1];
    assign out_3     = r_data[2];
    assign out_4     = r_data[3];
    assign out_valid = r_valid;

endmodule
`default_nettype wire
